// File: rtl/lfsr_bist_ctrl_if.sv
// Bundle between the test-access side, the BIST controller and the LFSR/CUT
// datapath.
//   master : test-access side. It drives start/abort/config and the CUT
//            response, and observes the status and LFSR control outputs.
//   slave  : the BIST controller.
// Signals:
//   start, abort             run control
//   seed, num_patterns,      run configuration, captured on an accepted start
//   golden
//   resp_in                  CUT response, compacted every RUN cycle
//   lfsr_rst, lfsr_seed,     LFSR load strobe, seed value and scan input
//   lfsr_scan_in
//   busy, done, pass         run status
//   signature, pattern_cnt   MISR contents and count of applied patterns
interface lfsr_bist_ctrl_if #(
    parameter int unsigned NBIT  = 4,
    parameter int unsigned CNT_W = 8
);
    logic             start;
    logic             abort;
    logic [NBIT-1:0]  seed;
    logic [CNT_W-1:0] num_patterns;
    logic [NBIT-1:0]  golden;
    logic [NBIT-1:0]  resp_in;
    logic             lfsr_rst;
    logic [NBIT-1:0]  lfsr_seed;
    logic             lfsr_scan_in;
    logic             busy;
    logic             done;
    logic             pass;
    logic [NBIT-1:0]  signature;
    logic [CNT_W-1:0] pattern_cnt;

    modport master (
        output start, abort, seed, num_patterns, golden, resp_in,
        input  lfsr_rst, lfsr_seed, lfsr_scan_in, busy, done, pass,
               signature, pattern_cnt
    );

    modport slave (
        input  start, abort, seed, num_patterns, golden, resp_in,
        output lfsr_rst, lfsr_seed, lfsr_scan_in, busy, done, pass,
               signature, pattern_cnt
    );
endinterface

// File: rtl/lfsr_bist_ctrl.sv
// BIST controller for a 4-bit LFSR pattern generator. It loads the seed,
// free-runs the LFSR for N patterns, and compacts the CUT response into a
// 4-bit MISR. It then compares the MISR against the golden signature.
// Ports:
//   clk  : clock. All state changes on the rising edge.
//   rst  : asynchronous reset, active low.
//   bus  : lfsr_bist_ctrl_if.slave. Holds control, config, CUT response,
//          LFSR controls and status.
module lfsr_bist_ctrl #(
    parameter int unsigned NBIT  = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    lfsr_bist_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEED = 2'd1,
        ST_RUN  = 2'd2,
        ST_CMP  = 2'd3
    } state_t;

    state_t           r_state,    w_state_nxt;
    logic [NBIT-1:0]  r_seed,     w_seed_nxt;
    logic [NBIT-1:0]  r_golden,   w_golden_nxt;
    logic [CNT_W-1:0] r_num,      w_num_nxt;
    logic [NBIT-1:0]  r_sig,      w_sig_nxt;
    logic [CNT_W-1:0] r_cnt,      w_cnt_nxt;
    logic             r_pass,     w_pass_nxt;
    logic             r_done,     w_done_nxt;
    logic             r_busy,     w_busy_nxt;
    logic             r_lfsr_rst, w_lfsr_rst_nxt;

    // MISR step: shift left, feed back taps 3 and 2, then XOR in the response
    logic [NBIT-1:0]  w_misr_step;
    assign w_misr_step = {r_sig[NBIT-2:0], r_sig[NBIT-1] ^ r_sig[NBIT-2]} ^ bus.resp_in;

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt  = r_state;
        w_seed_nxt   = r_seed;
        w_golden_nxt = r_golden;
        w_num_nxt    = r_num;
        w_sig_nxt    = r_sig;
        w_cnt_nxt    = r_cnt;
        w_pass_nxt   = r_pass;
        w_done_nxt   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                // A simultaneous abort wins over start
                if (bus.start && !bus.abort) begin
                    w_seed_nxt   = bus.seed;
                    w_num_nxt    = bus.num_patterns;
                    w_golden_nxt = bus.golden;
                    w_pass_nxt   = 1'b0;
                    w_state_nxt  = ST_SEED;
                end
            end
            ST_SEED: begin
                if (bus.abort) begin
                    w_pass_nxt  = 1'b0;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_sig_nxt   = '0;
                    w_cnt_nxt   = '0;
                    w_state_nxt = (r_num != '0) ? ST_RUN : ST_CMP;
                end
            end
            ST_RUN: begin
                if (bus.abort) begin
                    w_pass_nxt  = 1'b0;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_sig_nxt = w_misr_step;
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                    // Leave after the N-th compaction, so the counter stops at N
                    if (r_cnt == r_num - CNT_W'(1)) begin
                        w_state_nxt = ST_CMP;
                    end
                end
            end
            ST_CMP: begin
                if (bus.abort) begin
                    w_pass_nxt  = 1'b0;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_pass_nxt  = (r_sig == r_golden);
                    w_done_nxt  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // busy and lfsr_rst are registered decodes of the upcoming state
        w_busy_nxt     = (w_state_nxt != ST_IDLE);
        w_lfsr_rst_nxt = (w_state_nxt == ST_SEED);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_seed     <= '0;
            r_golden   <= '0;
            r_num      <= '0;
            r_sig      <= '0;
            r_cnt      <= '0;
            r_pass     <= 1'b0;
            r_done     <= 1'b0;
            r_busy     <= 1'b0;
            r_lfsr_rst <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_seed     <= w_seed_nxt;
            r_golden   <= w_golden_nxt;
            r_num      <= w_num_nxt;
            r_sig      <= w_sig_nxt;
            r_cnt      <= w_cnt_nxt;
            r_pass     <= w_pass_nxt;
            r_done     <= w_done_nxt;
            r_busy     <= w_busy_nxt;
            r_lfsr_rst <= w_lfsr_rst_nxt;
        end
    end

    assign bus.lfsr_rst     = r_lfsr_rst;
    assign bus.lfsr_seed    = r_seed;
    assign bus.lfsr_scan_in = 1'b0;
    assign bus.busy         = r_busy;
    assign bus.done         = r_done;
    assign bus.pass         = r_pass;
    assign bus.signature    = r_sig;
    assign bus.pattern_cnt  = r_cnt;

endmodule

// File: tb/tb_lfsr_bist_ctrl.sv
// Testbench for lfsr_bist_ctrl. Each accepted run pushes the expected
// {pass, signature, pattern_cnt} into a queue. A forked monitor pops one
// entry and compares it on every done pulse. Directed cycle checks cover
// timing, abort and reset behaviour.
module tb_lfsr_bist_ctrl;
    localparam int unsigned NBIT  = 4;
    localparam int unsigned CNT_W = 8;

    typedef struct packed {
        logic             pass;
        logic [NBIT-1:0]  sig;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lfsr_bist_ctrl_if #(.NBIT(NBIT), .CNT_W(CNT_W)) bif ();

    lfsr_bist_ctrl #(.NBIT(NBIT), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif.slave)
    );

    int   total     = 0;
    int   bad       = 0;
    int   done_seen = 0;
    exp_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue a start for one cycle; returns in cycle 1 (SEED)
    task automatic start_run(input logic [NBIT-1:0] s, input logic [CNT_W-1:0] n,
                             input logic [NBIT-1:0] g);
        bif.seed         = s;
        bif.num_patterns = n;
        bif.golden       = g;
        bif.start        = 1'b1;
        step();
        bif.start        = 1'b0;
    endtask

    initial begin
        int   d0;
        exp_t e;

        rst              = 1'b0;
        bif.start        = 1'b0;
        bif.abort        = 1'b0;
        bif.seed         = '0;
        bif.num_patterns = '0;
        bif.golden       = '0;
        bif.resp_in      = '0;

        // Scoreboard monitor: one expected entry per done pulse
        fork
            forever begin
                @(negedge clk);
                if (bif.done === 1'b1) begin
                    done_seen++;
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_done: got done=1 expected no pending run");
                    end else begin
                        e = exp_q.pop_front();
                        check("sb_pass",      32'(bif.pass),        32'(e.pass));
                        check("sb_signature", 32'(bif.signature),   32'(e.sig));
                        check("sb_count",     32'(bif.pattern_cnt), 32'(e.cnt));
                    end
                end
            end
        join_none

        // Reset state
        step();
        step();
        check("rst_busy",      32'(bif.busy),         0);
        check("rst_done",      32'(bif.done),         0);
        check("rst_pass",      32'(bif.pass),         0);
        check("rst_lfsr_rst",  32'(bif.lfsr_rst),     0);
        check("rst_scan_in",   32'(bif.lfsr_scan_in), 0);
        check("rst_seed",      32'(bif.lfsr_seed),    0);
        check("rst_signature", 32'(bif.signature),    0);
        check("rst_count",     32'(bif.pattern_cnt),  0);
        rst = 1'b1;
        step();

        // N=0: SEED then CMP directly, done in cycle 3
        bif.resp_in = 4'h0;
        exp_q.push_back('{1'b1, 4'h0, 8'd0});
        start_run(4'b1001, 8'd0, 4'h0);
        check("n0_lfsr_rst_c1",  32'(bif.lfsr_rst),  1);
        check("n0_lfsr_seed_c1", 32'(bif.lfsr_seed), 9);
        check("n0_busy_c1",      32'(bif.busy),      1);
        step();
        check("n0_lfsr_rst_c2",  32'(bif.lfsr_rst),  0);
        check("n0_busy_c2",      32'(bif.busy),      1);
        check("n0_done_c2",      32'(bif.done),      0);
        step();
        check("n0_done_c3",      32'(bif.done),      1);
        check("n0_busy_c3",      32'(bif.busy),      0);
        step();
        check("n0_done_c4",      32'(bif.done),      0);

        // N=3, resp 1, golden 7: signature 1, 3, 7
        bif.resp_in = 4'h1;
        exp_q.push_back('{1'b1, 4'h7, 8'd3});
        d0 = done_seen;
        start_run(4'h5, 8'd3, 4'h7);
        check("p3_seed_c1", 32'(bif.lfsr_seed), 5);
        step();
        check("p3_sig_c2",  32'(bif.signature),   0);
        check("p3_cnt_c2",  32'(bif.pattern_cnt), 0);
        step();
        check("p3_sig_c3",  32'(bif.signature),   1);
        step();
        check("p3_sig_c4",  32'(bif.signature),   3);
        check("p3_cnt_c4",  32'(bif.pattern_cnt), 2);
        step();
        check("p3_sig_c5",  32'(bif.signature),   7);
        check("p3_busy_c5", 32'(bif.busy),        1);
        check("p3_done_c5", 32'(bif.done),        0);
        step();
        check("p3_done_c6", 32'(bif.done),        1);
        check("p3_busy_c6", 32'(bif.busy),        0);
        step();
        check("p3_done_cnt", 32'(done_seen - d0), 1);
        check("p3_pass_hold", 32'(bif.pass),      1);
        check("p3_sig_hold",  32'(bif.signature), 7);

        // N=3, golden 6: fails, single done pulse
        exp_q.push_back('{1'b0, 4'h7, 8'd3});
        d0 = done_seen;
        start_run(4'h5, 8'd3, 4'h6);
        check("f3_pass_cleared", 32'(bif.pass), 0);
        for (int i = 0; i < 5; i++) step();
        check("f3_done_c6", 32'(bif.done), 1);
        check("f3_pass_c6", 32'(bif.pass), 0);
        step();
        step();
        check("f3_done_cnt", 32'(done_seen - d0), 1);

        // Abort during RUN cycle 2 of N=8: signature and count freeze
        d0 = done_seen;
        start_run(4'h3, 8'd8, 4'h0);
        step();
        step();
        bif.abort = 1'b1;
        step();
        bif.abort = 1'b0;
        check("ab_busy",      32'(bif.busy),        0);
        check("ab_done",      32'(bif.done),        0);
        check("ab_pass",      32'(bif.pass),        0);
        check("ab_signature", 32'(bif.signature),   1);
        check("ab_count",     32'(bif.pattern_cnt), 1);
        for (int i = 0; i < 12; i++) step();
        check("ab_no_done",   32'(done_seen - d0),  0);

        // start and abort together in IDLE: stays IDLE
        bif.start = 1'b1;
        bif.abort = 1'b1;
        step();
        check("sa_busy_c1",     32'(bif.busy),     0);
        check("sa_lfsr_rst_c1", 32'(bif.lfsr_rst), 0);
        step();
        check("sa_busy_c2",     32'(bif.busy),     0);
        bif.start = 1'b0;
        bif.abort = 1'b0;

        // Reset at RUN cycle 5 of N=10
        d0 = done_seen;
        start_run(4'hC, 8'd10, 4'h0);
        for (int i = 0; i < 5; i++) step();
        check("mr_sig_before", 32'(bif.signature),   14);
        check("mr_cnt_before", 32'(bif.pattern_cnt), 4);
        rst = 1'b0;
        #1;
        check("mr_busy",      32'(bif.busy),        0);
        check("mr_done",      32'(bif.done),        0);
        check("mr_pass",      32'(bif.pass),        0);
        check("mr_lfsr_rst",  32'(bif.lfsr_rst),    0);
        check("mr_signature", 32'(bif.signature),   0);
        check("mr_count",     32'(bif.pattern_cnt), 0);
        check("mr_seed",      32'(bif.lfsr_seed),   0);
        step();
        rst = 1'b1;
        step();
        check("mr_busy_after", 32'(bif.busy), 0);
        for (int i = 0; i < 14; i++) step();
        check("mr_no_done",    32'(done_seen - d0), 0);

        // Back-to-back N=1 runs with start held: done every 4 cycles
        bif.resp_in      = 4'hA;
        bif.seed         = 4'h1;
        bif.num_patterns = 8'd1;
        bif.golden       = 4'hA;
        for (int i = 0; i < 3; i++) exp_q.push_back('{1'b1, 4'hA, 8'd1});
        d0 = done_seen;
        bif.start = 1'b1;
        for (int cyc = 1; cyc <= 13; cyc++) begin
            step();
            if (cyc == 9) bif.start = 1'b0;
            check($sformatf("bb_done_c%0d", cyc), 32'(bif.done),
                  ((cyc % 4 == 0) && (cyc <= 12)) ? 32'd1 : 32'd0);
            if (cyc == 4) check("bb_pass_c4", 32'(bif.pass), 1);
            if (cyc == 5) check("bb_pass_c5", 32'(bif.pass), 0);
            if (cyc == 5) check("bb_lfsr_rst_c5", 32'(bif.lfsr_rst), 1);
        end
        step();
        check("bb_done_cnt", 32'(done_seen - d0), 3);

        // Bounded drain of any outstanding expectations
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
        check("queue_drained", 32'(exp_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
